// File: rtl/fft_cbfp_6.sv
// fft_cbfp_6 : block-floating-point normalizer for the stage-5 twiddle products.
//
// Incoming beats (ARRAY complex lanes of IN_DATA bits) are collected into
// blocks of BEATS beats in a ping-pong buffer. While a block is written, the
// smallest redundant-sign count over all of its samples is tracked. That
// value is the block shift m. A drained block is re-emitted with every
// sample shifted left by m, rounded half-up to OUT_DATA bits and saturated.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   valid_in            input beat qualifier
//   din_re / din_im     ARRAY packed signed lanes, lane i at [i*IN_DATA +: IN_DATA]
//   valid_out           output beat qualifier (no gaps inside a block)
//   dout_re / dout_im   ARRAY packed signed lanes, lane i at [i*OUT_DATA +: OUT_DATA]
//   exp_out             block shift m, constant over a block, 0 when idle
//   blk_first/blk_last  flag the first / last beat of a block
module fft_cbfp_6 #(
  parameter int IN_DATA  = 25,
  parameter int OUT_DATA = 13,
  parameter int ARRAY    = 16,
  parameter int BEATS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [IN_DATA*ARRAY-1:0]  din_re,
  input  logic [IN_DATA*ARRAY-1:0]  din_im,
  output logic                      valid_out,
  output logic [OUT_DATA*ARRAY-1:0] dout_re,
  output logic [OUT_DATA*ARRAY-1:0] dout_im,
  output logic [4:0]                exp_out,
  output logic                      blk_first,
  output logic                      blk_last
);

  localparam int S     = IN_DATA - OUT_DATA;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W = 2 * IN_DATA * ARRAY;

  localparam logic [CW-1:0]             LAST    = CW'(BEATS - 1);
  localparam logic [4:0]                RS_MAX  = 5'(IN_DATA - 1);
  localparam logic signed [IN_DATA:0]   HALF    = (IN_DATA+1)'(1) <<< (S - 1);
  localparam logic signed [OUT_DATA:0]  POS_MAX = (OUT_DATA+1)'((1 << (OUT_DATA - 1)) - 1);

  typedef enum logic [0:0] {IDLE, DRAIN} state_t;

  // Number of bits directly below the MSB that repeat the sign bit.
  function automatic logic [4:0] rs_count(input logic signed [IN_DATA-1:0] x);
    logic [4:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = IN_DATA - 2; i >= 0; i--) begin
      if (run && (x[i] == x[IN_DATA-1])) n = n + 5'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

  // Shift by the block exponent, round half-up, saturate. The left shift
  // cannot overflow because m never exceeds any sample's sign redundancy;
  // the one extra bit in the rounding sum absorbs the carry, and only the
  // positive end can leave the output range.
  function automatic logic signed [OUT_DATA-1:0] scale_round_sat(
    input logic signed [IN_DATA-1:0] x,
    input logic [4:0]                m
  );
    logic signed [IN_DATA-1:0] scaled;
    logic signed [IN_DATA:0]   biased;
    logic signed [OUT_DATA:0]  r;
    scaled = x <<< m;
    biased = {scaled[IN_DATA-1], scaled} + HALF;
    r      = biased[IN_DATA:S];
    if (r > POS_MAX) return {1'b0, {(OUT_DATA-1){1'b1}}};
    return r[OUT_DATA-1:0];
  endfunction

  logic [ROW_W-1:0] mem [2][BEATS];
  logic [4:0]       m_bank [2];

  logic [CW-1:0] wr_cnt;
  logic          wr_bank;
  logic [4:0]    min_run;
  logic [1:0]    full;
  logic [4:0]    beat_min;
  logic [4:0]    blk_min;

  state_t        state, state_nxt;
  logic [CW-1:0] rd_cnt;
  logic          rd_bank;
  logic          rd_en;
  logic          drain_end;

  logic [ROW_W-1:0]          row_p0;
  logic [4:0]                m_p0;
  logic [OUT_DATA*ARRAY-1:0] re_p0;
  logic [OUT_DATA*ARRAY-1:0] im_p0;

  // ---- write side: running minimum of sign redundancy over the block ----
  always_comb begin
    beat_min = RS_MAX;
    for (int i = 0; i < ARRAY; i++) begin
      if (rs_count(din_re[i*IN_DATA +: IN_DATA]) < beat_min)
        beat_min = rs_count(din_re[i*IN_DATA +: IN_DATA]);
      if (rs_count(din_im[i*IN_DATA +: IN_DATA]) < beat_min)
        beat_min = rs_count(din_im[i*IN_DATA +: IN_DATA]);
    end
    blk_min = (beat_min < min_run) ? beat_min : min_run;
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem[wr_bank][wr_cnt] <= {din_im, din_re};
      if (wr_cnt == LAST) m_bank[wr_bank] <= blk_min;
    end
  end

  // Write and read sides never touch the same full bit in one cycle: a bank
  // being drained is never the bank being filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      min_run <= RS_MAX;
      full    <= '0;
    end else begin
      if (valid_in) begin
        if (wr_cnt == LAST) begin
          wr_cnt        <= '0;
          wr_bank       <= ~wr_bank;
          min_run       <= RS_MAX;
          full[wr_bank] <= 1'b1;
        end else begin
          wr_cnt  <= wr_cnt + CW'(1);
          min_run <= blk_min;
        end
      end
      if (drain_end) full[rd_bank] <= 1'b0;
    end
  end

  // ---- read side: drain FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    drain_end = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) state_nxt = DRAIN;
      end
      DRAIN: begin
        rd_en = 1'b1;
        if (rd_cnt == LAST) begin
          drain_end = 1'b1;
          state_nxt = full[~rd_bank] ? DRAIN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_en) begin
      if (rd_cnt == LAST) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  // ---- p0: buffer read and per-sample scaling ----
  always_comb begin
    row_p0 = mem[rd_bank][rd_cnt];
    m_p0   = m_bank[rd_bank];
    re_p0  = '0;
    im_p0  = '0;
    for (int i = 0; i < ARRAY; i++) begin
      re_p0[i*OUT_DATA +: OUT_DATA] = scale_round_sat(row_p0[i*IN_DATA +: IN_DATA], m_p0);
      im_p0[i*OUT_DATA +: OUT_DATA] = scale_round_sat(row_p0[(ARRAY+i)*IN_DATA +: IN_DATA], m_p0);
    end
  end

  // ---- p1: output register, zeroed outside valid beats ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
      exp_out   <= '0;
      dout_re   <= '0;
      dout_im   <= '0;
    end else begin
      valid_out <= rd_en;
      blk_first <= rd_en && (rd_cnt == '0);
      blk_last  <= drain_end;
      exp_out   <= rd_en ? m_p0  : '0;
      dout_re   <= rd_en ? re_p0 : '0;
      dout_im   <= rd_en ? im_p0 : '0;
    end
  end

endmodule

// File: tb/tb_fft_cbfp_6.sv
// Directed bench for fft_cbfp_6: one task per scenario, inline comparisons.
module tb_fft_cbfp_6;

  localparam int IN_DATA  = 25;
  localparam int OUT_DATA = 13;
  localparam int ARRAY    = 16;
  localparam int BEATS    = 4;
  localparam int IW = IN_DATA * ARRAY;
  localparam int OW = OUT_DATA * ARRAY;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [IW-1:0] din_re = '0;
  logic [IW-1:0] din_im = '0;
  logic          valid_out;
  logic [OW-1:0] dout_re;
  logic [OW-1:0] dout_im;
  logic [4:0]    exp_out;
  logic          blk_first;
  logic          blk_last;

  fft_cbfp_6 #(.IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA), .ARRAY(ARRAY), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
    .valid_out(valid_out), .dout_re(dout_re), .dout_im(dout_im), .exp_out(exp_out),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int last_edge = 0;

  logic [IW-1:0] blk_re [BEATS];
  logic [IW-1:0] blk_im [BEATS];

  logic [OW-1:0] q_re [$];
  logic [OW-1:0] q_im [$];
  logic [4:0]    q_exp [$];
  logic          q_first [$];
  logic          q_last [$];
  int            q_edge [$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Collect every valid output beat with the number of the edge that produced it.
  always @(negedge clk) begin
    if (valid_out) begin
      q_re.push_back(dout_re);
      q_im.push_back(dout_im);
      q_exp.push_back(exp_out);
      q_first.push_back(blk_first);
      q_last.push_back(blk_last);
      q_edge.push_back(edge_cnt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_exp.delete();
    q_first.delete(); q_last.delete(); q_edge.delete();
  endtask

  task automatic fill_const(input logic [IN_DATA-1:0] vr, input logic [IN_DATA-1:0] vi);
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < ARRAY; i++) begin
        blk_re[b][i*IN_DATA +: IN_DATA] = vr;
        blk_im[b][i*IN_DATA +: IN_DATA] = vi;
      end
  endtask

  task automatic fill_random(input int sh);
    logic signed [IN_DATA-1:0] v;
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < ARRAY; i++) begin
        v = IN_DATA'($urandom); v = v >>> sh;
        blk_re[b][i*IN_DATA +: IN_DATA] = v;
        v = IN_DATA'($urandom); v = v >>> sh;
        blk_im[b][i*IN_DATA +: IN_DATA] = v;
      end
  endtask

  task automatic drive_block(input int first, input int count, input int max_gap);
    for (int b = first; b < first + count; b++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(negedge clk); valid_in = 1'b0; din_re = '0; din_im = '0;
      end
      @(negedge clk);
      valid_in = 1'b1; din_re = blk_re[b]; din_im = blk_im[b];
      last_edge = edge_cnt + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); valid_in = 1'b0; din_re = '0; din_im = '0;
    end
  endtask

  task automatic wait_out(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q_re.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  function automatic logic [OW-1:0] rep(input logic [OUT_DATA-1:0] v);
    logic [OW-1:0] r;
    for (int i = 0; i < ARRAY; i++) r[i*OUT_DATA +: OUT_DATA] = v;
    return r;
  endfunction

  // Largest k with -2^(W-1-k) <= x < 2^(W-1-k).
  function automatic int rs_model(input longint x);
    for (int k = IN_DATA - 1; k >= 0; k--)
      if (x >= -(64'sd1 <<< (IN_DATA-1-k)) && x < (64'sd1 <<< (IN_DATA-1-k))) return k;
    return 0;
  endfunction

  function automatic logic [OUT_DATA-1:0] out_model(input longint x, input int m);
    longint t;
    t = (x * (64'sd1 <<< m)) + 2048;
    t = t >>> (IN_DATA - OUT_DATA);
    if (t > 4095) t = 4095;
    if (t < -4096) t = -4096;
    return OUT_DATA'(t);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    #1;
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_tests++; if (dout_re !== '0) begin n_fail++; $display("FAIL reset_re got %h want 0", dout_re); end
    n_tests++; if (dout_im !== '0) begin n_fail++; $display("FAIL reset_im got %h want 0", dout_im); end
    n_tests++; if (exp_out !== 5'd0) begin n_fail++; $display("FAIL reset_exp got %0d want 0", exp_out); end
    n_tests++; if (blk_first !== 1'b0 || blk_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got %b%b want 00", blk_first, blk_last); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_const256();
    bit ok;
    fill_const(25'd256, 25'd256);
    clear_q();
    drive_block(0, BEATS, 0);
    idle(1);
    wait_out(BEATS, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL const256_timeout got %0d beats want %0d", q_re.size(), BEATS); end
    else begin
      n_tests++; if (q_edge[0] !== last_edge + 2) begin
        n_fail++; $display("FAIL const256_latency got edge %0d want %0d", q_edge[0], last_edge + 2); end
      for (int k = 0; k < BEATS; k++) begin
        n_tests++; if (q_re[k] !== rep(13'd2048)) begin n_fail++; $display("FAIL const256_re beat %0d got %h want %h", k, q_re[k], rep(13'd2048)); end
        n_tests++; if (q_im[k] !== rep(13'd2048)) begin n_fail++; $display("FAIL const256_im beat %0d got %h want %h", k, q_im[k], rep(13'd2048)); end
        n_tests++; if (q_exp[k] !== 5'd15) begin n_fail++; $display("FAIL const256_exp beat %0d got %0d want 15", k, q_exp[k]); end
        n_tests++; if (q_first[k] !== (k == 0) || q_last[k] !== (k == BEATS-1)) begin
          n_fail++; $display("FAIL const256_flags beat %0d got %b%b want %b%b", k, q_first[k], q_last[k], k == 0, k == BEATS-1); end
        n_tests++; if (q_edge[k] !== q_edge[0] + k) begin n_fail++; $display("FAIL const256_gap beat %0d got edge %0d want %0d", k, q_edge[k], q_edge[0] + k); end
      end
    end
  endtask

  task automatic test_neg_full();
    bit ok;
    logic [OW-1:0] want;
    fill_const(25'd1, 25'd1);
    blk_re[0][5*IN_DATA +: IN_DATA] = 25'h1000000;
    clear_q();
    drive_block(0, BEATS, 0);
    idle(1);
    wait_out(BEATS, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL negfull_timeout got %0d beats want %0d", q_re.size(), BEATS); end
    else begin
      for (int k = 0; k < BEATS; k++) begin
        want = '0;
        if (k == 0) want[5*OUT_DATA +: OUT_DATA] = 13'h1000;
        n_tests++; if (q_re[k] !== want) begin n_fail++; $display("FAIL negfull_re beat %0d got %h want %h", k, q_re[k], want); end
        n_tests++; if (q_im[k] !== '0) begin n_fail++; $display("FAIL negfull_im beat %0d got %h want 0", k, q_im[k]); end
        n_tests++; if (q_exp[k] !== 5'd0) begin n_fail++; $display("FAIL negfull_exp beat %0d got %0d want 0", k, q_exp[k]); end
      end
    end
  endtask

  task automatic test_pos_sat();
    bit ok;
    logic [OW-1:0] want;
    fill_const(25'd0, 25'd0);
    blk_im[2][15*IN_DATA +: IN_DATA] = 25'h0FFFFFF;
    clear_q();
    drive_block(0, BEATS, 0);
    idle(1);
    wait_out(BEATS, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL possat_timeout got %0d beats want %0d", q_re.size(), BEATS); end
    else begin
      for (int k = 0; k < BEATS; k++) begin
        want = '0;
        if (k == 2) want[15*OUT_DATA +: OUT_DATA] = 13'h0FFF;
        n_tests++; if (q_im[k] !== want) begin n_fail++; $display("FAIL possat_im beat %0d got %h want %h", k, q_im[k], want); end
        n_tests++; if (q_re[k] !== '0) begin n_fail++; $display("FAIL possat_re beat %0d got %h want 0", k, q_re[k]); end
        n_tests++; if (q_exp[k] !== 5'd0) begin n_fail++; $display("FAIL possat_exp beat %0d got %0d want 0", k, q_exp[k]); end
      end
    end
  endtask

  task automatic test_zero();
    bit ok;
    fill_const(25'd0, 25'd0);
    clear_q();
    drive_block(0, BEATS, 0);
    idle(1);
    wait_out(BEATS, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL zero_timeout got %0d beats want %0d", q_re.size(), BEATS); end
    else begin
      for (int k = 0; k < BEATS; k++) begin
        n_tests++; if (q_exp[k] !== 5'd24) begin n_fail++; $display("FAIL zero_exp beat %0d got %0d want 24", k, q_exp[k]); end
        n_tests++; if (q_re[k] !== '0 || q_im[k] !== '0) begin n_fail++; $display("FAIL zero_data beat %0d got %h/%h want 0", k, q_re[k], q_im[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int first_last;
    logic [OW-1:0] w_re [3];
    logic [OW-1:0] w_im [3];
    logic [4:0]    w_exp [3];
    w_re[0] = rep(13'd2048); w_im[0] = rep(13'h1800); w_exp[0] = 5'd15;
    w_re[1] = rep(13'd2048); w_im[1] = rep(13'd1536); w_exp[1] = 5'd3;
    w_re[2] = rep(13'd2048); w_im[2] = rep(13'h1800); w_exp[2] = 5'd0;
    clear_q();
    fill_const(25'd256, -25'sd256);
    drive_block(0, BEATS, 0);
    first_last = last_edge;
    fill_const(25'h0100000, 25'h00C0000);
    drive_block(0, BEATS, 0);
    fill_const(25'h0800000, 25'h1800000);
    drive_block(0, BEATS, 0);
    idle(1);
    wait_out(3*BEATS, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout got %0d beats want %0d", q_re.size(), 3*BEATS); end
    else begin
      n_tests++; if (q_edge[0] !== first_last + 2) begin
        n_fail++; $display("FAIL b2b_latency got edge %0d want %0d", q_edge[0], first_last + 2); end
      for (int k = 0; k < 3*BEATS; k++) begin
        n_tests++; if (q_edge[k] !== q_edge[0] + k) begin n_fail++; $display("FAIL b2b_gap beat %0d got edge %0d want %0d", k, q_edge[k], q_edge[0] + k); end
        n_tests++; if (q_exp[k] !== w_exp[k/BEATS]) begin n_fail++; $display("FAIL b2b_exp beat %0d got %0d want %0d", k, q_exp[k], w_exp[k/BEATS]); end
        n_tests++; if (q_re[k] !== w_re[k/BEATS]) begin n_fail++; $display("FAIL b2b_re beat %0d got %h want %h", k, q_re[k], w_re[k/BEATS]); end
        n_tests++; if (q_im[k] !== w_im[k/BEATS]) begin n_fail++; $display("FAIL b2b_im beat %0d got %h want %h", k, q_im[k], w_im[k/BEATS]); end
        n_tests++; if (q_first[k] !== (k % BEATS == 0) || q_last[k] !== (k % BEATS == BEATS-1)) begin
          n_fail++; $display("FAIL b2b_flags beat %0d got %b%b want %b%b", k, q_first[k], q_last[k], k % BEATS == 0, k % BEATS == BEATS-1); end
      end
    end
    idle(4);
    #1;
    n_tests++; if (valid_out !== 1'b0 || dout_re !== '0 || dout_im !== '0 || exp_out !== 5'd0) begin
      n_fail++; $display("FAIL idle_zero got v=%b exp=%0d re=%h want all 0", valid_out, exp_out, dout_re); end
  endtask

  task automatic test_gap_reset();
    bit ok;
    int m;
    logic signed [IN_DATA-1:0] v;
    logic [OW-1:0] w_re, w_im;
    clear_q();
    fill_random(3);
    drive_block(0, 2, 2);
    @(negedge clk);
    valid_in = 1'b0; din_re = '0; din_im = '0; rst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL gaprst_inreset got %b want 0", valid_out); end
    rst = 1'b0;
    idle(10);
    n_tests++; if (q_re.size() !== 0) begin n_fail++; $display("FAIL gaprst_aborted got %0d beats want 0", q_re.size()); end
    fill_random($urandom_range(9, 2));
    drive_block(0, BEATS, 3);
    idle(1);
    wait_out(BEATS, ok);
    idle(6);
    n_tests++;
    if (!ok || q_re.size() !== BEATS) begin
      n_fail++; $display("FAIL gaprst_count got %0d beats want %0d", q_re.size(), BEATS);
    end else begin
      m = IN_DATA - 1;
      for (int b = 0; b < BEATS; b++)
        for (int i = 0; i < ARRAY; i++) begin
          v = blk_re[b][i*IN_DATA +: IN_DATA]; if (rs_model(longint'(v)) < m) m = rs_model(longint'(v));
          v = blk_im[b][i*IN_DATA +: IN_DATA]; if (rs_model(longint'(v)) < m) m = rs_model(longint'(v));
        end
      for (int k = 0; k < BEATS; k++) begin
        for (int i = 0; i < ARRAY; i++) begin
          v = blk_re[k][i*IN_DATA +: IN_DATA]; w_re[i*OUT_DATA +: OUT_DATA] = out_model(longint'(v), m);
          v = blk_im[k][i*IN_DATA +: IN_DATA]; w_im[i*OUT_DATA +: OUT_DATA] = out_model(longint'(v), m);
        end
        n_tests++; if (q_exp[k] !== 5'(m)) begin n_fail++; $display("FAIL gaprst_exp beat %0d got %0d want %0d", k, q_exp[k], m); end
        n_tests++; if (q_re[k] !== w_re) begin n_fail++; $display("FAIL gaprst_re beat %0d got %h want %h", k, q_re[k], w_re); end
        n_tests++; if (q_im[k] !== w_im) begin n_fail++; $display("FAIL gaprst_im beat %0d got %h want %h", k, q_im[k], w_im); end
        n_tests++; if (q_first[k] !== (k == 0) || q_last[k] !== (k == BEATS-1)) begin
          n_fail++; $display("FAIL gaprst_flags beat %0d got %b%b want %b%b", k, q_first[k], q_last[k], k == 0, k == BEATS-1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_const256();
    test_neg_full();
    test_pos_sat();
    test_zero();
    test_back_to_back();
    test_gap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_cbfp_6.md
# fft_cbfp_6

Convergent block-floating-point normalizer that sits directly downstream of the stage-5 twiddle-multiply stage. It consumes the 16-lane, 25-bit complex products and collects them into blocks of BEATS beats. It finds the block-wide common left shift, then re-emits the block scaled, rounded and saturated to the next stage's input width, together with the block exponent. A ping-pong buffer lets one block be captured while the previous block drains.

## Interface
- IN_DATA, 25, input sample width (signed two's complement); must be ≤ 32
- OUT_DATA, 13, output sample width (signed); must be < IN_DATA
- ARRAY, 16, lanes per beat
- BEATS, 4, valid beats per block; must be ≥ 2
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  input beat qualifier
- din_re  in  IN_DATA×ARRAY  signed real lanes
- din_im  in  IN_DATA×ARRAY  signed imaginary lanes
- valid_out  out  1  output beat qualifier
- dout_re  out  OUT_DATA×ARRAY  scaled real lanes
- dout_im  out  OUT_DATA×ARRAY  scaled imaginary lanes
- exp_out  out  5  block shift m; held constant across a block's beats
- blk_first  out  1  high with the first beat of a block
- blk_last  out  1  high with the last beat of a block

## Operation
- Redundant-sign count rs(x): the number of bits below the MSB that equal the MSB. Range 0..IN_DATA-1.
  - rs(0) = rs(-1) = IN_DATA-1.
  - rs(-2^(IN_DATA-1)) = 0.
- Write side:
  - wr_cnt counts 0..BEATS-1 on each valid_in.
  - Each valid beat is stored in bank wr_bank at row wr_cnt.
  - A running min of rs over all 2·ARRAY values of each beat is kept.
  - valid_in gaps are allowed anywhere; the counter simply holds.
- On the beat where wr_cnt = BEATS-1:
  - m is latched for that bank.
  - The bank is marked full, wr_bank toggles, wr_cnt wraps to 0 and the running min re-seeds to IN_DATA-1.
- Read FSM:
  - IDLE: when a full bank is pending, go to DRAIN with rd_cnt = 0.
  - DRAIN: read one row per cycle. When rd_cnt = BEATS-1, clear that bank's full flag. Then go to DRAIN of the other bank if it is full in that cycle, else go to IDLE.
- Per-sample arithmetic, with S = IN_DATA-OUT_DATA:
  - scaled = x <<< m. This cannot overflow by construction.
  - r = (scaled + 2^(S-1)) >>> S.
  - Saturate r to [-2^(OUT_DATA-1), 2^(OUT_DATA-1)-1]. Only the positive side can overflow.
- The output register stage registers dout_re, dout_im, exp_out, blk_first, blk_last and valid_out.
- Outputs are zero whenever valid_out = 0. exp_out is zero outside a block.
- Overrun is impossible when valid_in rate ≤ 1 beat/cycle: drain rate equals fill rate and the bank is double-buffered. No error flag is needed.

## Timing
- Reset (async assert, sync-safe release) clears:
  - wr_cnt, rd_cnt, wr_bank and full flags
  - the FSM to IDLE
  - all outputs to 0
- Buffer contents need no reset.
- Latency: if the last input beat of a block is sampled at edge t, that block's first output beat is valid after edge t+2.
- Remaining beats follow on consecutive cycles, t+2 .. t+BEATS+1. valid_out never gaps inside a block.
- Back-to-back blocks: with continuous valid_in, output is continuous with no bubble between blocks. Each block carries its own exp_out.
- A bank is never written while it is being read. The earliest rewrite of a bank starts the cycle after its last read.
- Reset mid-block or mid-drain: the partial block and pending banks are discarded. The first block after release starts at wr_cnt = 0, bank 0.
- Simultaneous events are legal and handled the same cycle: block completion on the write side and drain end on the read side.

## Test plan
- One block, every lane re = im = 256:
  - Required: exp_out = 15; all dout = 2048.
  - Required: first valid_out 2 cycles after the 4th input beat; blk_first on beat 0, blk_last on beat 3.
- One block with a single lane = -2^24 and all others = 1:
  - Required: exp_out = 0; that lane = -4096; all others = 0.
- One block with a single lane = 2^24-1 and the rest 0:
  - Required: exp_out = 0; that lane saturates to 4095, not 4096.
- All-zero block:
  - Required: exp_out = 24; all outputs 0.
- Three blocks on continuous valid_in with distinct magnitudes (exponents 15, 3, 0):
  - Required: 12 consecutive valid beats; exp_out changes exactly at each blk_first.
- Randomized valid_in gaps with one rst pulse after 2 beats of a block:
  - Required: no output from the aborted block.
  - Required: the next 4 beats form a block whose output matches a reference model.
